// File: rtl/jtag_cmd_sequencer.sv
// Command sequencer driving a Wishbone-attached JTAG master.
// Turns clock/control/shift/status commands into register-level bus cycles.
module jtag_cmd_sequencer #(
  parameter logic [29:0] BASE_ADR   = 30'h0,
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_data,
  output logic        rsp_err,
  output logic [29:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE, WRITE, GAP, POLL, READ, RESP
  } state_t;

  localparam logic [1:0]  OP_SHIFT = 2'd2;
  localparam logic [1:0]  OP_STAT  = 2'd3;
  localparam logic [29:0] ADR_SH   = BASE_ADR + 30'd8;
  localparam logic [29:0] ADR_ST   = BASE_ADR + 30'd12;
  localparam logic [10:0] POLL_MAX = 11'(POLL_LIMIT);

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] data_q;
  logic [10:0] poll_cnt;
  logic        gap_read;
  logic [23:0] rsp_data_q;
  logic        rsp_err_q;

  logic accept, st_busy, timeout, poll_ack;
  logic unused_dat;

  assign accept     = cmd_valid & cmd_ready;
  assign st_busy    = wbm_dat_i[0];
  assign timeout    = (poll_cnt + 11'd1) >= POLL_MAX;
  assign poll_ack   = (state == POLL) & wbm_ack_i;
  assign unused_dat = ^wbm_dat_i[7:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nxt = (cmd_op == OP_STAT) ? POLL : WRITE;
      WRITE:
        if (wbm_ack_i)
          state_nxt = (op_q == OP_SHIFT) ? GAP : IDLE;
      GAP:
        state_nxt = gap_read ? READ : POLL;
      POLL:
        if (wbm_ack_i) begin
          if (op_q != OP_SHIFT)     state_nxt = RESP;
          else if (!st_busy)        state_nxt = GAP;
          else if (timeout)         state_nxt = RESP;
          else                      state_nxt = GAP;
        end
      READ:
        if (wbm_ack_i) state_nxt = RESP;
      RESP:
        if (rsp_ready) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // gap_read steers GAP toward the SHIFT read once STATUS reports idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      data_q     <= '0;
      poll_cnt   <= '0;
      gap_read   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= cmd_op;
        data_q   <= cmd_data;
        gap_read <= 1'b0;
        if (cmd_op == OP_SHIFT) poll_cnt <= '0;
      end
      if (poll_ack) begin
        if (op_q == OP_STAT) begin
          rsp_data_q <= {22'h0, wbm_dat_i[1:0]};
          rsp_err_q  <= 1'b0;
        end else begin
          poll_cnt <= poll_cnt + 11'd1;
          gap_read <= ~st_busy;
          if (st_busy && timeout) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
      end
      if (state == READ && wbm_ack_i) begin
        rsp_data_q <= wbm_dat_i[31:8];
        rsp_err_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    unique case (state)
      WRITE: begin
        wbm_cyc_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_adr_o = BASE_ADR + {26'h0, op_q, 2'b00};
        wbm_dat_o = data_q;
      end
      POLL: begin
        wbm_cyc_o = 1'b1;
        wbm_adr_o = ADR_ST;
      end
      READ: begin
        wbm_cyc_o = 1'b1;
        wbm_adr_o = ADR_SH;
      end
      default: ;
    endcase
  end

  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_sel_o = 4'hF;
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy_o    = (state != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Directed bench for jtag_cmd_sequencer.
// A small Wishbone slave model supplies STATUS/SHIFT data.
module tb_jtag_cmd_sequencer;

  localparam logic [29:0] BASE   = 30'h100;
  localparam logic [29:0] ADR_ST = BASE + 30'd12;
  localparam logic [29:0] ADR_SH = BASE + 30'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [23:0] rsp_data;
  logic        rsp_err;
  logic [29:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i = 1'b0;
  logic        busy_o;

  always #5 clk = ~clk;

  jtag_cmd_sequencer #(.BASE_ADR(BASE), .POLL_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .busy_o(busy_o)
  );

  int          busy_polls = 0;
  logic [31:0] status_base = '0;
  logic [31:0] shift_rd = '0;
  int          st_snap = 0;

  int          wr_cnt = 0, st_cnt = 0, sh_cnt = 0, hs_cnt = 0, viol_cnt = 0;
  logic [29:0] wr_adr = '0;
  logic [31:0] wr_dat = '0, wr_dat_prev = '0;
  logic        prev_ack = 1'b0, prev_open = 1'b0, prev_we = 1'b0;
  logic [29:0] prev_adr = '0;
  logic [31:0] prev_dat = '0;

  always @(posedge clk) begin
    if (rst) wbm_ack_i <= 1'b0;
    else     wbm_ack_i <= wbm_cyc_o & wbm_stb_o & ~wbm_ack_i;
  end

  always_comb begin
    wbm_dat_i = 32'hBAD0_BAD0;
    if (wbm_adr_o == ADR_ST)
      wbm_dat_i = ((st_cnt - st_snap) < busy_polls) ?
                  (status_base | 32'h1) : status_base;
    else if (wbm_adr_o == ADR_SH)
      wbm_dat_i = shift_rd;
  end

  always @(posedge clk) begin
    if (rst) begin
      prev_ack  <= 1'b0;
      prev_open <= 1'b0;
    end else begin
      if (wbm_cyc_o && wbm_ack_i) begin
        if (wbm_we_o) begin
          wr_cnt      <= wr_cnt + 1;
          wr_adr      <= wbm_adr_o;
          wr_dat      <= wbm_dat_o;
          wr_dat_prev <= wr_dat;
        end else if (wbm_adr_o == ADR_ST) begin
          st_cnt <= st_cnt + 1;
        end else if (wbm_adr_o == ADR_SH) begin
          sh_cnt <= sh_cnt + 1;
        end
      end
      if (rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;
      if (prev_ack && wbm_cyc_o) viol_cnt <= viol_cnt + 1;
      if (prev_open && !(wbm_cyc_o && wbm_stb_o &&
          wbm_adr_o == prev_adr && wbm_we_o == prev_we &&
          wbm_dat_o == prev_dat))
        viol_cnt <= viol_cnt + 1;
      if (wbm_cyc_o && wbm_stb_o && wbm_sel_o != 4'hF)
        viol_cnt <= viol_cnt + 1;
      prev_ack  <= wbm_cyc_o & wbm_ack_i;
      prev_open <= wbm_cyc_o & ~wbm_ack_i;
      prev_adr  <= wbm_adr_o;
      prev_we   <= wbm_we_o;
      prev_dat  <= wbm_dat_o;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          busy;
    logic [31:0] stat;
    logic [31:0] shrd;
    int          n_wr;
    logic [29:0] wadr;
    int          n_st;
    int          n_sh;
    int          n_rsp;
    logic [23:0] rdata;
    logic        rerr;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] op, input logic [31:0] data, input int busy,
    input logic [31:0] stat, input logic [31:0] shrd, input int n_wr,
    input logic [29:0] wadr, input int n_st, input int n_sh,
    input int n_rsp, input logic [23:0] rdata, input logic rerr);
    vec_t v;
    v.op = op; v.data = data; v.busy = busy; v.stat = stat;
    v.shrd = shrd; v.n_wr = n_wr; v.wadr = wadr; v.n_st = n_st;
    v.n_sh = n_sh; v.n_rsp = n_rsp; v.rdata = rdata; v.rerr = rerr;
    return v;
  endfunction

  // called at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [1:0] op, input logic [31:0] d,
                       input string tag);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, " accept_timeout"}, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w0, s0, h0, r0, x0, n;
    string t;
    t = $sformatf("v%0d", idx);
    busy_polls  = v.busy;
    status_base = v.stat;
    shift_rd    = v.shrd;
    st_snap = st_cnt;
    w0 = wr_cnt; s0 = st_cnt; h0 = sh_cnt; r0 = hs_cnt; x0 = viol_cnt;
    issue(v.op, v.data, t);
    if (v.n_rsp != 0) begin
      wait_rsp(t);
      chk({t, " rsp_data"}, 32'(rsp_data), 32'(v.rdata));
      chk({t, " rsp_err"}, 32'(rsp_err), 32'(v.rerr));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end else begin
      n = 0;
      while (busy_o && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk({t, " idle_latency"}, n, 2);
    end
    chk({t, " cmd_ready"}, 32'(cmd_ready), 1);
    chk({t, " rsp_valid_low"}, 32'(rsp_valid), 0);
    chk({t, " n_wr"}, wr_cnt - w0, v.n_wr);
    if (v.n_wr != 0) begin
      chk({t, " wr_adr"}, 32'(wr_adr), 32'(v.wadr));
      chk({t, " wr_dat"}, wr_dat, v.data);
    end
    chk({t, " n_status"}, st_cnt - s0, v.n_st);
    chk({t, " n_shift_rd"}, sh_cnt - h0, v.n_sh);
    chk({t, " n_rsp"}, hs_cnt - r0, v.n_rsp);
    chk({t, " bus_proto"}, viol_cnt - x0, 0);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, x0, r0;
    vecs[0] = mk(2'd0, 32'h0000_0003, 0, 0, 0,
                 1, BASE, 0, 0, 0, 24'h0, 1'b0);
    vecs[1] = mk(2'd1, 32'h0000_0005, 0, 0, 0,
                 1, BASE + 30'd4, 0, 0, 0, 24'h0, 1'b0);
    vecs[2] = mk(2'd2, 32'hA500_0008, 3, 0, 32'h5A00_0000,
                 1, BASE + 30'd8, 4, 1, 1, 24'h5A0000, 1'b0);
    vecs[3] = mk(2'd2, 32'h1234_5618, 0, 0, 32'hDEAD_BEEF,
                 1, BASE + 30'd8, 1, 1, 1, 24'hDEADBE, 1'b0);
    vecs[4] = mk(2'd2, 32'h0000_00FF, 1000, 0, 32'hFFFF_FFFF,
                 1, BASE + 30'd8, 4, 0, 1, 24'h0, 1'b1);
    vecs[5] = mk(2'd3, 32'h0, 1000, 0, 0,
                 0, BASE, 1, 0, 1, 24'h1, 1'b0);
    vecs[6] = mk(2'd3, 32'h0, 0, 32'h2, 0,
                 0, BASE, 1, 0, 1, 24'h2, 1'b0);
    vecs[7] = mk(2'd3, 32'h0, 0, 32'hFFFF_FFF3, 0,
                 0, BASE, 1, 0, 1, 24'h3, 1'b0);

    repeat (3) @(negedge clk);
    chk("rst cyc", 32'(wbm_cyc_o), 0);
    chk("rst stb", 32'(wbm_stb_o), 0);
    chk("rst we", 32'(wbm_we_o), 0);
    chk("rst adr", 32'(wbm_adr_o), 0);
    chk("rst dat", wbm_dat_o, 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rsp_data", 32'(rsp_data), 0);
    chk("rst rsp_err", 32'(rsp_err), 0);
    chk("rst busy", 32'(busy_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst cmd_ready", 32'(cmd_ready), 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // response back-pressure: rsp must hold for 5 cycles
    busy_polls = 0; status_base = 32'h2; st_snap = st_cnt;
    issue(2'd3, 32'h0, "bp");
    wait_rsp("bp");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold%0d valid", k), 32'(rsp_valid), 1);
      chk($sformatf("bp hold%0d data", k), 32'(rsp_data), 32'h2);
      chk($sformatf("bp hold%0d cmd_ready", k), 32'(cmd_ready), 0);
      @(negedge clk);
    end
    chk("bp hs cmd_ready", 32'(cmd_ready), 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp after rsp_valid", 32'(rsp_valid), 0);
    chk("bp after cmd_ready", 32'(cmd_ready), 1);

    // reset while a STATUS read strobe is outstanding
    busy_polls = 0; status_base = 32'h0; st_snap = st_cnt;
    r0 = hs_cnt;
    issue(2'd3, 32'h0, "rpoll");
    chk("rpoll stb_before", 32'(wbm_stb_o), 1);
    rst = 1'b1;
    #1;
    chk("rpoll cyc", 32'(wbm_cyc_o), 0);
    chk("rpoll stb", 32'(wbm_stb_o), 0);
    chk("rpoll rsp_valid", 32'(rsp_valid), 0);
    chk("rpoll busy", 32'(busy_o), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rpoll no_rsp", 32'(rsp_valid), 0);
    chk("rpoll no_hs", hs_cnt - r0, 0);
    chk("rpoll idle_bus", 32'(wbm_cyc_o), 0);
    run_vec(vecs[6], 6);

    // back-to-back SET_CTRL with cmd_valid held high
    w0 = wr_cnt; x0 = viol_cnt;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 32'h2;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_data = 32'h3;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("b2b second_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (busy_o && n < 50) begin @(negedge clk); n++; end
    chk("b2b busy", 32'(busy_o), 0);
    chk("b2b n_wr", wr_cnt - w0, 2);
    chk("b2b adr", 32'(wr_adr), 32'(BASE + 30'd4));
    chk("b2b dat1", wr_dat_prev, 32'h2);
    chk("b2b dat2", wr_dat, 32'h3);
    chk("b2b bus_proto", viol_cnt - x0, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_sequencer.md
JTAG_CMD_SEQUENCER -- requirements
Module: jtag_cmd_sequencer

Interface
REQ-001 SHALL provide parameter BASE_ADR, default 30'h0, base byte-style address of the JTAG master controller register block.
REQ-002 SHALL provide parameter POLL_LIMIT, default 1023, the maximum number of STATUS reads per SHIFT before timeout.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-007 cmd_op  in  2  0=SET_CLK, 1=SET_CTRL, 2=SHIFT, 3=READ_STATUS.
REQ-008 cmd_data  in  32  operand (SET_CLK [7:0]; SET_CTRL [2:0]; SHIFT full word: [31:8] TDI payload, [7:0] bit length).
REQ-009 rsp_valid  out  1  response present.
REQ-010 rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
REQ-011 rsp_data  out  24  captured TDO bits, or STATUS[1:0] zero-extended.
REQ-012 rsp_err  out  1  SHIFT poll timeout.
REQ-013 wbm_adr_o  out  30; wbm_dat_o  out  32; wbm_sel_o  out  4; wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each: Wishbone master.
REQ-014 wbm_dat_i  in  32; wbm_ack_i  in  1: Wishbone master returns.
REQ-015 busy_o  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 Register offsets SHALL be CLK=0, CTRL=1, SHIFT=2, STATUS=3; wbm_adr_o = BASE_ADR + (offset<<2); wbm_sel_o constant 4'hF.
REQ-017 FSM states SHALL be IDLE, WRITE, GAP, POLL, READ, RESP.
REQ-018 cmd_ready SHALL be high only in IDLE; on accept, op and data are latched and the FSM leaves IDLE the next cycle.
REQ-019 SET_CLK/SET_CTRL: IDLE->WRITE (we=1, dat_o=cmd_data) ->IDLE on ack; no response generated.
REQ-020 SHIFT: IDLE->WRITE to SHIFT ->GAP ->POLL (read STATUS) ->GAP while STATUS[0]=1 ->READ (read SHIFT) ->RESP with rsp_data=wbm_dat_i[31:8], rsp_err=0.
REQ-021 READ_STATUS: IDLE->POLL single read ->RESP with rsp_data={22'h0,wbm_dat_i[1:0]}, rsp_err=0; no busy re-poll.
REQ-022 Bus cycle: cyc/stb/adr/we/dat SHALL be asserted together and held stable until the cycle wbm_ack_i=1; cyc/stb drop the following cycle.
REQ-023 At least one cycle with cyc=stb=0 SHALL separate any two consecutive bus transactions (GAP state; slave acks on stb rising edge).
REQ-024 Read data SHALL be sampled only in the cycle wbm_ack_i=1; ack while cyc=0 SHALL be ignored.
REQ-025 Poll counter (11 bits) SHALL clear on SHIFT accept and increment per STATUS read; when it reaches POLL_LIMIT with STATUS[0] still 1, go to RESP with rsp_err=1, rsp_data=0, no SHIFT read.
REQ-026 RESP: rsp_valid held with stable rsp_data/rsp_err until rsp_ready; transition to IDLE the cycle after handshake; rsp_valid=0 outside RESP.
REQ-027 A command SHALL never be accepted while a response is pending (single outstanding command).

Reset
REQ-028 rst SHALL force, asynchronously: state=IDLE, cyc/stb/we=0, adr/dat_o=0, rsp_valid=0, rsp_data=0, rsp_err=0, poll counter=0, busy_o=0; cmd_ready=1 from the first cycle after rst deasserts.
REQ-029 rst mid-transaction SHALL abandon the bus cycle and any pending response; no command is replayed.

Verification
REQ-030 SET_CLK data 0x03 -> one write, adr=BASE+0x0, dat=0x00000003, no rsp, busy_o low 1 cycle after ack.
REQ-031 SHIFT data 0xA5000008, slave busy for 3 polls then STATUS=0, SHIFT reads 0x5A000000 -> write at BASE+0x8, 4 STATUS reads at BASE+0xC each separated by >=1 idle cycle, rsp_data=0x5A0000, rsp_err=0.
REQ-032 SHIFT with STATUS stuck 0x1, POLL_LIMIT=4 -> exactly 4 STATUS reads, rsp_err=1, rsp_data=0, no SHIFT read.
REQ-033 READ_STATUS with STATUS=0x2 and rsp_ready low 5 cycles -> rsp_valid held stable 5 cycles, rsp_data=0x000002, cmd_ready low until 1 cycle after handshake.
REQ-034 rst pulsed while stb high in POLL -> cyc/stb drop immediately, rsp_valid=0, next cmd accepted normally.
REQ-035 cmd_valid held high across back-to-back SET_CTRL 0x2, 0x3 -> two writes to BASE+0x4 with >=1 idle bus cycle between.
